// File: rtl/rgb_ycbcr_conv.sv
// RGB to YCbCr converter: BT.601/BT.709 full-range, rounded and saturated,
// 4:4:4 or 4:2:2 co-sited output, fixed 4-cycle latency with matching strobes.
module rgb_ycbcr_conv #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              std_sel,
  input  logic              fmt_sel,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_red,
  input  logic [DATA_W-1:0] per_img_green,
  input  logic [DATA_W-1:0] per_img_blue,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Y,
  output logic [DATA_W-1:0] post_img_Cb,
  output logic [DATA_W-1:0] post_img_Cr,
  output logic              post_chroma_sel
);

  localparam int PW = DATA_W + 8;
  localparam int SW = DATA_W + 10;
  localparam logic signed [SW-1:0] C_OFF = SW'(2 ** (DATA_W + 7));
  localparam logic signed [SW-1:0] C_RND = SW'(128);
  localparam logic signed [SW-1:0] C_MAX = SW'(2 ** DATA_W - 1);

  // Coefficient magnitudes; signs are fixed per term in the S2 sums.
  function automatic logic [7:0] coef(input logic std, input int idx);
    logic [7:0] c;
    case (idx)
      0:       c = std ? 8'd54  : 8'd77;
      1:       c = std ? 8'd183 : 8'd150;
      2:       c = std ? 8'd19  : 8'd29;
      3:       c = std ? 8'd29  : 8'd43;
      4:       c = std ? 8'd99  : 8'd85;
      5:       c = 8'd128;
      6:       c = 8'd128;
      7:       c = std ? 8'd116 : 8'd107;
      8:       c = std ? 8'd12  : 8'd21;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  function automatic logic signed [SW-1:0] ext(input logic [PW-1:0] p);
    return $signed({2'b00, p});
  endfunction

  function automatic logic [DATA_W-1:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    logic [DATA_W-1:0]    o;
    r = s + C_RND;
    r = r >>> 8;
    if (r < 0) begin
      o = {DATA_W{1'b0}};
    end else if (r > C_MAX) begin
      o = {DATA_W{1'b1}};
    end else begin
      o = r[DATA_W-1:0];
    end
    return o;
  endfunction

  logic vs_prev_q, std_act_q, fmt_act_q, phase_q;
  logic vs_prev_d, std_act_d, fmt_act_d, phase_d;
  // ctl bits: vsync, href, clken, pixel phase, fmt_act
  logic [4:0] ctl1_q, ctl2_q, ctl3_q, ctl1_d;
  logic [PW-1:0] prod_q [9];
  logic [PW-1:0] prod_d [9];
  logic signed [SW-1:0] sum_q [3];
  logic signed [SW-1:0] sum_d [3];
  logic [DATA_W-1:0] res_q [3];
  logic [DATA_W-1:0] res_d [3];
  logic [DATA_W-1:0] comp_s [3];
  logic [DATA_W-1:0] y_q, cb_q, cr_q, cr_store_q, y_d, cb_d, cr_d, cr_store_d;
  logic sel_q, sel_d, vs_q, hr_q, ck_q;

  // Frame-boundary mode capture and pixel phase tracking
  always_comb begin
    vs_prev_d = per_frame_vsync;
    if (per_frame_vsync && !vs_prev_q) begin
      std_act_d = std_sel;
      fmt_act_d = fmt_sel;
    end else begin
      std_act_d = std_act_q;
      fmt_act_d = fmt_act_q;
    end
    if (per_frame_href) begin
      phase_d = phase_q ^ per_frame_clken;
    end else begin
      phase_d = 1'b0;
    end
  end

  // Datapath next-state: products, signed sums, round/clamp
  always_comb begin
    comp_s[0] = per_img_red;
    comp_s[1] = per_img_green;
    comp_s[2] = per_img_blue;
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = PW'(comp_s[i % 3]) * PW'(coef(std_act_q, i));
    end
    ctl1_d = {per_frame_vsync, per_frame_href, per_frame_clken,
              per_frame_href & phase_q, fmt_act_q};
    sum_d[0] = ext(prod_q[0]) + ext(prod_q[1]) + ext(prod_q[2]);
    sum_d[1] = C_OFF - ext(prod_q[3]) - ext(prod_q[4]) + ext(prod_q[5]);
    sum_d[2] = C_OFF + ext(prod_q[6]) - ext(prod_q[7]) - ext(prod_q[8]);
    for (int k = 0; k < 3; k++) begin
      res_d[k] = round_sat(sum_q[k]);
    end
  end

  // Output format mux; even 4:2:2 pixels stash Cr for their odd partner
  always_comb begin
    y_d        = {DATA_W{1'b0}};
    cb_d       = {DATA_W{1'b0}};
    cr_d       = {DATA_W{1'b0}};
    sel_d      = 1'b0;
    cr_store_d = cr_store_q;
    if (!ctl3_q[3]) begin
      cr_store_d = {DATA_W{1'b0}};
    end else if (ctl3_q[0]) begin
      y_d = res_q[0];
      if (ctl3_q[1]) begin
        cb_d  = cr_store_q;
        sel_d = 1'b1;
      end else begin
        cb_d = res_q[1];
        if (ctl3_q[2]) begin
          cr_store_d = res_q[2];
        end else begin
          cr_store_d = cr_store_q;
        end
      end
    end else begin
      y_d  = res_q[0];
      cb_d = res_q[1];
      cr_d = res_q[2];
    end
  end

  // All state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q  <= 1'b0;
      std_act_q  <= 1'b0;
      fmt_act_q  <= 1'b0;
      phase_q    <= 1'b0;
      ctl1_q     <= 5'd0;
      ctl2_q     <= 5'd0;
      ctl3_q     <= 5'd0;
      for (int i = 0; i < 9; i++) prod_q[i] <= {PW{1'b0}};
      for (int k = 0; k < 3; k++) begin
        sum_q[k] <= {SW{1'b0}};
        res_q[k] <= {DATA_W{1'b0}};
      end
      y_q        <= {DATA_W{1'b0}};
      cb_q       <= {DATA_W{1'b0}};
      cr_q       <= {DATA_W{1'b0}};
      cr_store_q <= {DATA_W{1'b0}};
      sel_q      <= 1'b0;
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      ck_q       <= 1'b0;
    end else begin
      vs_prev_q  <= vs_prev_d;
      std_act_q  <= std_act_d;
      fmt_act_q  <= fmt_act_d;
      phase_q    <= phase_d;
      ctl1_q     <= ctl1_d;
      ctl2_q     <= ctl1_q;
      ctl3_q     <= ctl2_q;
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int k = 0; k < 3; k++) begin
        sum_q[k] <= sum_d[k];
        res_q[k] <= res_d[k];
      end
      y_q        <= y_d;
      cb_q       <= cb_d;
      cr_q       <= cr_d;
      cr_store_q <= cr_store_d;
      sel_q      <= sel_d;
      vs_q       <= ctl3_q[4];
      hr_q       <= ctl3_q[3];
      ck_q       <= ctl3_q[2];
    end
  end

  assign post_frame_vsync = vs_q;
  assign post_frame_href  = hr_q;
  assign post_frame_clken = ck_q;
  assign post_img_Y       = y_q;
  assign post_img_Cb      = cb_q;
  assign post_img_Cr      = cr_q;
  assign post_chroma_sel  = sel_q;

endmodule

// File: tb/tb_rgb_ycbcr_conv.sv
// Scoreboard bench for rgb_ycbcr_conv (DATA_W = 8) with hand-computed vectors.
module tb_rgb_ycbcr_conv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       std_sel = 1'b0, fmt_sel = 1'b0;
  logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
  logic       o_vs, o_hr, o_ck, o_sel;
  logic [7:0] o_y, o_cb, o_cr;

  int checks = 0;
  int errors = 0;

  // colours: white, black, red, green, blue, grey -> {R,G,B} and {Y,Cb,Cr}
  logic [23:0] rgb_t  [6] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080};
  logic [23:0] e601_t [6] = '{{8'd255, 8'd128, 8'd128}, {8'd0, 8'd128, 8'd128}, {8'd77, 8'd85, 8'd255},
                              {8'd149, 8'd43, 8'd21}, {8'd29, 8'd255, 8'd107}, {8'd128, 8'd128, 8'd128}};
  logic [23:0] e709_t [6] = '{{8'd255, 8'd128, 8'd128}, {8'd0, 8'd128, 8'd128}, {8'd54, 8'd99, 8'd255},
                              {8'd182, 8'd29, 8'd12}, {8'd19, 8'd255, 8'd116}, {8'd128, 8'd128, 8'd128}};

  logic        mode_std = 1'b0, mode_fmt = 1'b0, phase_tb = 1'b0;
  logic [7:0]  stored_tb = 8'd0;
  logic [24:0] exp_cur = 25'd0;
  logic [24:0] sb [$];
  logic [2:0]  dl [4];

  rgb_ycbcr_conv #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .std_sel(std_sel), .fmt_sel(fmt_sel),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_red(r_in), .per_img_green(g_in), .per_img_blue(b_in),
    .post_frame_vsync(o_vs), .post_frame_href(o_hr), .post_frame_clken(o_ck),
    .post_img_Y(o_y), .post_img_Cb(o_cb), .post_img_Cr(o_cr), .post_chroma_sel(o_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int c);
    logic [23:0] e;
    {r_in, g_in, b_in} = rgb_t[c];
    e = mode_std ? e709_t[c] : e601_t[c];
    href  = 1'b1;
    clken = 1'b1;
    if (!mode_fmt) begin
      exp_cur = {e, 1'b0};
    end else if (!phase_tb) begin
      exp_cur   = {e[23:8], 8'd0, 1'b0};
      stored_tb = e[7:0];
      phase_tb  = 1'b1;
    end else begin
      exp_cur  = {e[23:16], stored_tb, 8'd0, 1'b1};
      phase_tb = 1'b0;
    end
  endtask

  task automatic pix(input int c);
    vsync = 1'b0;
    set_pix(c);
    step();
  endtask

  task automatic gap();
    href  = 1'b1;
    clken = 1'b0;
    step();
  endtask

  task automatic blank(input int n);
    href     = 1'b0;
    clken    = 1'b0;
    phase_tb = 1'b0;
    repeat (n) step();
  endtask

  task automatic frame_start(input logic s, input logic f);
    std_sel = s;
    fmt_sel = f;
    href    = 1'b0;
    clken   = 1'b0;
    vsync   = 1'b1;
    step();
    mode_std = s;
    mode_fmt = f;
    vsync    = 1'b0;
    step();
  endtask

  // expected-response push at the sampling edge
  always @(posedge clk) begin
    if (!rst && clken && href) sb.push_back(exp_cur);
  end

  // reference strobe delay line
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dl[i] <= 3'd0;
    end else begin
      dl[0] <= {vsync, href, clken};
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end
  end

  // monitor on the inactive edge
  always @(negedge clk) begin
    logic [24:0] e;
    check("strobes", {29'd0, o_vs, o_hr, o_ck}, {29'd0, dl[3]});
    if (rst || !o_hr) begin
      check("idle_data", {7'd0, o_y, o_cb, o_cr, o_sel}, 32'd0);
    end
    if (!rst && o_ck) begin
      if (sb.size() == 0) begin
        check("unexpected_pixel", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pixel_Y",   {24'd0, o_y},   {24'd0, e[24:17]});
        check("pixel_Cb",  {24'd0, o_cb},  {24'd0, e[16:9]});
        check("pixel_Cr",  {24'd0, o_cr},  {24'd0, e[8:1]});
        check("pixel_sel", {31'd0, o_sel}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    // reset with inputs active
    set_pix(0);
    vsync = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    blank(3);

    // BT.601, 4:4:4
    frame_start(1'b0, 1'b0);
    pix(0); pix(1); pix(2); pix(3); pix(4); pix(5); gap(); pix(2);
    blank(4);

    // BT.709; a mid-line request must wait for the next frame
    frame_start(1'b1, 1'b0);
    pix(2); pix(3); pix(4);
    std_sel = 1'b0;
    pix(2); pix(0);
    blank(2);
    pix(2);
    blank(3);

    // BT.601, 4:2:2 with a clken gap and an odd-length line
    frame_start(1'b0, 1'b1);
    pix(2); pix(4); pix(2); gap(); pix(4); pix(3);
    blank(2);
    pix(4); pix(2); pix(3); pix(4);
    blank(3);

    // asynchronous reset mid-frame; mode falls back to defaults
    frame_start(1'b1, 1'b0);
    repeat (6) pix(2);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", {24'd0, o_y, o_cb, o_cr} | {31'd0, o_vs | o_hr | o_ck | o_sel}, 32'd0);
    sb.delete();
    mode_std = 1'b0;
    mode_fmt = 1'b0;
    phase_tb = 1'b0;
    step();
    step();
    rst = 1'b0;
    pix(2); pix(4); pix(0);
    blank(8);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_ycbcr_conv.md
# rgb_ycbcr_conv

Parametrised RGB-to-YCbCr colour-space converter for the camera video pipeline, placed directly after capture/demosaic and ahead of the YCbCr-domain filters. It supports a configurable component width and a run-time choice of BT.601 or BT.709 full-range coefficients. Every output is rounded and saturated. The output format is either 4:4:4 or 4:2:2 co-sited chroma. Mode changes take effect only at frame boundaries, and the vsync/href/clken strobes are delayed to match the fixed pipeline latency.

## Interface
- DATA_W, 8, component width for R/G/B in and Y/Cb/Cr out; legal range 8..12.
- clk  input  1  pixel clock; all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high; clears every register.
- std_sel  input  1  coefficient set request: 0 = BT.601, 1 = BT.709.
- fmt_sel  input  1  output format request: 0 = 4:4:4, 1 = 4:2:2.
- per_frame_vsync  input  1  input frame sync, active-high.
- per_frame_href  input  1  input line valid.
- per_frame_clken  input  1  input pixel valid.
- per_img_red / per_img_green / per_img_blue  input  DATA_W each  input components, unsigned.
- post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  input strobes delayed by 4 cycles.
- post_img_Y  output  DATA_W  luma.
- post_img_Cb  output  DATA_W  in 4:4:4: Cb; in 4:2:2: the multiplexed chroma sample.
- post_img_Cr  output  DATA_W  in 4:4:4: Cr; in 4:2:2: forced to 0.
- post_chroma_sel  output  1  in 4:2:2: 0 = post_img_Cb carries Cb, 1 = it carries Cr; in 4:4:4: 0.

## Operation
- Active mode registers std_act and fmt_act are reset to 0 (BT.601, 4:4:4).
  - Both load std_sel/fmt_sel on the cycle a rising edge of per_frame_vsync is detected (registered previous vsync, compared with current).
  - Changes at any other time are ignored until the next frame.
- Coefficients are 8-bit fractional (scale 256).
  - BT.601 set: Y = 77, 150, 29; Cb = -43, -85, 128; Cr = 128, -107, -21.
  - BT.709 set: Y = 54, 183, 19; Cb = -29, -99, 128; Cr = 128, -116, -12.
- Arithmetic:
  - Products are DATA_W+8 bits unsigned.
  - Sums are signed, DATA_W+10 bits.
  - Chroma sums add the offset 2^(DATA_W+7).
  - All three sums add 128 for rounding, then shift right by 8.
  - Results are clamped to [0, 2^DATA_W-1]; negative results clamp to 0.
- Pipeline:
  - S1: the nine products are registered, using std_act.
  - S2: the three signed sums are registered.
  - S3: round, shift and clamp are registered.
  - S4: format mux into the output registers.
  - The pipeline advances every clk regardless of clken.
- Pixel phase bit:
  - Cleared while per_frame_href = 0.
  - Toggles on each cycle with per_frame_href & per_frame_clken.
  - Is carried down the pipeline alongside the data, and so is fmt_act.
- 4:2:2 output:
  - Even-phase pixel: outputs its own Cb, post_chroma_sel = 0, and stores its Cr.
  - Odd-phase pixel: outputs the stored Cr of the preceding even pixel, post_chroma_sel = 1.
  - Y is always per-pixel.
- An odd-length line ends on an even pixel; its stored Cr is discarded at href low.
- While post_frame_href = 0, post_img_Y/Cb/Cr and post_chroma_sel are driven to 0.

## Timing
- Latency is exactly 4 clk cycles from input sample to output, for data and for all three strobes.
- Throughput is one pixel per clk; back-to-back clken is supported.
- Reset values:
  - All outputs are 0.
  - All pipeline, strobe-delay, phase and stored-Cr registers are 0.
  - std_act = fmt_act = 0.
- Reset mid-frame: outputs go to 0 asynchronously. After release, the first 4 cycles output strobes = 0, and the mode stays at the defaults until the next vsync rising edge.
- A mode request and a vsync rising edge in the same cycle: the new mode applies to the first pixel sampled one cycle later or afterwards.

## Test plan
- Reset with inputs active: all outputs 0 during reset and for 4 cycles after release; std_act = 0 and fmt_act = 0.
- BT.601, DATA_W = 8, R = G = B = 255 -> Y = 255, Cb = 128, Cr = 128 exactly 4 cycles later; R = G = B = 0 -> Y = 0, Cb = 128, Cr = 128.
- BT.601, pure red (255, 0, 0) -> Y = 77, Cb = 85, Cr = 255 (saturated from 256).
- std_sel = 1 applied before a vsync rising edge, pure red -> Y = 54, Cb = 99, Cr = 255; std_sel toggled mid-line -> output unchanged until the next frame.
- 4:2:2 mode, line of red then blue pixel pairs:
  - Red pixel -> Cb = 85 with sel = 0, then Cr = 255 with sel = 1.
  - Blue pixel Y = 29.
  - post_img_Cr = 0 throughout; phase restarts at 0 on each new line.
- Random RGB stream (DATA_W = 8 and 10) with random clken/href gaps, compared with a golden model: bit-exact Y/Cb/Cr and strobes delayed exactly 4 cycles.
